// File: rtl/capture_readout.sv
// capture_readout: packs 14-bit ADC samples two-per-word into 32-bit words,
// buffers them in a FIFO and presents them through a first-word-fall-through
// output register with valid/ready handshake and per-record last flag.
module capture_readout #(
    parameter int ADDR_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [13:0] data_in,
    input  logic               write_enable,
    input  logic [23:0]        max_sample_cnt,
    output logic [31:0]        m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
    output logic [ADDR_W:0]    word_count,
    output logic               overflow,
    input  logic               clear_overflow,
    output logic [15:0]        record_count
);
    localparam int DATA_W = 14;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    typedef enum logic { EMPTY, HAVE_LOW } pack_state_t;

    function automatic logic signed [15:0] sext16(input logic signed [DATA_W-1:0] s);
        return {{(16-DATA_W){s[DATA_W-1]}}, s};
    endfunction

    pack_state_t               state_p0, state_nxt;
    logic signed [DATA_W-1:0]  low_p0;
    logic                      armed;
    logic                      we_prev;
    logic                      we_eff;
    logic                      eor;
    logic                      load_low;
    logic                      emit;
    logic [31:0]               emit_word;

    logic [31:0]               word_p1;
    logic                      vld_p1;

    logic [31:0]               mem [DEPTH];
    logic [ADDR_W-1:0]         wr_ptr;
    logic [ADDR_W-1:0]         rd_ptr;
    logic [ADDR_W:0]           fifo_cnt;
    logic [23:0]               out_idx;
    logic [23:0]               w_last;
    logic                      wr_ok;
    logic                      drop;
    logic                      pop;
    logic                      xfer;

    // After reset, samples are ignored until write_enable has been seen low,
    // so a record already in flight at reset release is not half-captured.
    assign we_eff = write_enable & armed;
    assign eor    = we_prev & ~we_eff;

    // ---- stage p0: sample packer ----
    // Packer next-state: pair samples, flush a lone low half at end of record.
    always_comb begin
        state_nxt = state_p0;
        load_low  = 1'b0;
        emit      = 1'b0;
        emit_word = '0;
        case (state_p0)
            EMPTY: begin
                if (we_eff) begin
                    load_low  = 1'b1;
                    state_nxt = HAVE_LOW;
                end
            end
            HAVE_LOW: begin
                if (we_eff) begin
                    emit      = 1'b1;
                    emit_word = {sext16(data_in), sext16(low_p0)};
                    state_nxt = EMPTY;
                end else if (eor) begin
                    emit      = 1'b1;
                    emit_word = {16'h0000, sext16(low_p0)};
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Packer control state, arming, record boundary tracking and record count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0     <= EMPTY;
            armed        <= 1'b0;
            we_prev      <= 1'b0;
            record_count <= '0;
            vld_p1       <= 1'b0;
        end else begin
            state_p0 <= state_nxt;
            armed    <= armed | ~write_enable;
            we_prev  <= we_eff;
            vld_p1   <= emit;
            if (eor)
                record_count <= record_count + 16'd1;
        end
    end

    // Held low-half sample and completed word (datapath, no reset needed).
    always_ff @(posedge clk) begin
        if (load_low)
            low_p0 <= data_in;
        if (emit)
            word_p1 <= emit_word;
    end

    // ---- stage p1: FIFO write / output register ----
    // A full FIFO drops the incoming word even if a read frees a slot this cycle.
    assign wr_ok  = vld_p1 & (fifo_cnt != FULL_CNT);
    assign drop   = vld_p1 & (fifo_cnt == FULL_CNT);
    assign xfer   = m_valid & m_ready;
    assign pop    = (fifo_cnt != '0) & (~m_valid | m_ready);
    assign w_last = max_sample_cnt >> 1;
    assign m_last = m_valid & (out_idx == w_last);
    assign word_count = fifo_cnt + (ADDR_W+1)'(m_valid);

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= word_p1;
    end

    // Pointers, occupancy, output register, record word index and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            out_idx  <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop) begin
                m_data  <= mem[rd_ptr];
                m_valid <= 1'b1;
                rd_ptr  <= rd_ptr + ADDR_W'(1);
            end else if (xfer) begin
                m_valid <= 1'b0;
            end
            case ({wr_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (ADDR_W+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (ADDR_W+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (xfer)
                out_idx <= (out_idx == w_last) ? '0 : out_idx + 24'd1;
            if (drop)
                overflow <= 1'b1;
            else if (clear_overflow)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_capture_readout.sv
// Testbench for capture_readout: directed vectors plus randomized records
// checked against a queue-based packing model.
module tb_capture_readout;
    localparam int ADDR_W = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [13:0] data_in = '0;
    logic               write_enable = 1'b0;
    logic [23:0]        max_sample_cnt = '0;
    logic [31:0]        m_data;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic               m_last;
    logic [ADDR_W:0]    word_count;
    logic               overflow;
    logic               clear_overflow = 1'b0;
    logic [15:0]        record_count;

    int          n_checks = 0;
    int          n_fail = 0;
    int          exp_records = 0;
    bit          rand_ready = 0;
    int          stim[$];
    logic [32:0] obs_q[$];
    logic [32:0] exp_q[$];

    capture_readout #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .write_enable(write_enable),
        .max_sample_cnt(max_sample_cnt), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .word_count(word_count),
        .overflow(overflow), .clear_overflow(clear_overflow), .record_count(record_count)
    );

    always #5 clk = ~clk;

    // Record every transfer (m_valid & m_ready held through the next rising edge).
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready)
            obs_q.push_back({m_last, m_data});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready)
            m_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Expected words of one record from the samples in stim.
    task automatic model_record(input int msc);
        int w;
        int k;
        logic [31:0] lo;
        logic [31:0] hi;
        w = msc / 2 + 1;
        k = 0;
        for (int i = 0; i < stim.size(); i += 2) begin
            lo = stim[i] & 32'h0000FFFF;
            hi = (i + 1 < stim.size()) ? (stim[i+1] & 32'h0000FFFF) : 32'h0;
            exp_q.push_back({(k == w - 1), (hi << 16) | lo});
            k++;
        end
    endtask

    task automatic drive_record(input int msc);
        max_sample_cnt = 24'(msc);
        for (int i = 0; i < stim.size(); i++) begin
            data_in      = 14'(stim[i]);
            write_enable = 1'b1;
            step();
        end
        write_enable = 1'b0;
        step();
        exp_records++;
    endtask

    task automatic drain(input int limit);
        int c;
        c = 0;
        while (obs_q.size() < exp_q.size() && c < limit) begin
            step();
            c++;
        end
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_ready = 1'b1;
        write_enable = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        n_checks++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last: got %b expected 0", m_last); end
        n_checks++; if (m_data !== 32'h0) begin n_fail++; $display("FAIL reset_m_data: got %h expected 0", m_data); end
        n_checks++; if (word_count !== '0) begin n_fail++; $display("FAIL reset_word_count: got %0d expected 0", word_count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_checks++; if (record_count !== 16'h0) begin n_fail++; $display("FAIL reset_record_count: got %0d expected 0", record_count); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        step();
    endtask

    task automatic test_basic();
        obs_q.delete(); exp_q.delete();
        m_ready = 1'b1;
        stim = '{1, 2, -1, -2};
        exp_q.push_back({1'b0, 32'h00020001});
        exp_q.push_back({1'b1, 32'hFFFEFFFF});
        drive_record(3);
        drain(50);
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_count: got %0d words expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_word%0d: got last=%b data=%h expected last=%b data=%h", i, obs_q[i][32], obs_q[i][31:0], exp_q[i][32], exp_q[i][31:0]); end
        end
        n_checks++; if (record_count !== 16'd1) begin n_fail++; $display("FAIL basic_record_count: got %0d expected 1", record_count); end
    endtask

    task automatic test_odd_record();
        obs_q.delete(); exp_q.delete();
        m_ready = 1'b1;
        stim = '{5, 6, 7};
        exp_q.push_back({1'b0, 32'h00060005});
        exp_q.push_back({1'b1, 32'h00000007});
        drive_record(2);
        drain(50);
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL odd_count: got %0d words expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL odd_word%0d: got last=%b data=%h expected last=%b data=%h", i, obs_q[i][32], obs_q[i][31:0], exp_q[i][32], exp_q[i][31:0]); end
        end
        n_checks++; if (record_count !== 16'(exp_records)) begin n_fail++; $display("FAIL odd_record_count: got %0d expected %0d", record_count, exp_records); end
    endtask

    task automatic test_fwft_stall();
        m_ready = 1'b0;
        max_sample_cnt = 24'd1;
        data_in = 14'sd100; write_enable = 1'b1;
        step();
        data_in = -14'sd100;
        step();
        write_enable = 1'b0;
        exp_records++;
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL fwft_early_valid: got %b expected 0", m_valid); end
        step();
        n_checks++; if (m_valid !== 1'b0 || word_count !== 3'd1) begin n_fail++; $display("FAIL fwft_write_edge: got valid=%b count=%0d expected valid=0 count=1", m_valid, word_count); end
        step();
        n_checks++; if (m_valid !== 1'b1 || m_data !== 32'hFF9C0064 || m_last !== 1'b1) begin n_fail++; $display("FAIL fwft_valid: got valid=%b data=%h last=%b expected 1 ff9c0064 1", m_valid, m_data, m_last); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== 32'hFF9C0064) begin n_fail++; $display("FAIL stall_hold%0d: got valid=%b data=%h expected 1 ff9c0064", i, m_valid, m_data); end
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        n_checks++; if (m_valid !== 1'b0 || word_count !== '0) begin n_fail++; $display("FAIL fwft_release: got valid=%b count=%0d expected 0 0", m_valid, word_count); end
        n_checks++; if (record_count !== 16'(exp_records)) begin n_fail++; $display("FAIL fwft_record_count: got %0d expected %0d", record_count, exp_records); end
    endtask

    task automatic test_back_to_back();
        obs_q.delete(); exp_q.delete();
        m_ready = 1'b0;
        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back(int'($urandom_range(0, 16383)) - 8192);
        model_record(7);
        drive_record(7);
        step(); step();
        n_checks++; if (word_count !== 3'd4) begin n_fail++; $display("FAIL b2b_stored: got %0d expected 4", word_count); end
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (m_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid%0d: got %b expected 1", i, m_valid); end
            step();
        end
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b expected 0", m_valid); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_word%0d: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 33'h0, exp_q[i]); end
        end
    endtask

    task automatic test_random();
        int msc;
        obs_q.delete(); exp_q.delete();
        rand_ready = 1;
        for (int r = 0; r < 10; r++) begin
            msc = int'($urandom_range(0, 9));
            stim.delete();
            for (int i = 0; i <= msc; i++) stim.push_back(int'($urandom_range(0, 16383)) - 8192);
            model_record(msc);
            drive_record(msc);
            drain(200);
        end
        rand_ready = 0;
        m_ready = 1'b0;
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL random_count: got %0d words expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random_word%0d: got last=%b data=%h expected last=%b data=%h", i, obs_q[i][32], obs_q[i][31:0], exp_q[i][32], exp_q[i][31:0]); end
        end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL random_overflow: got %b expected 0", overflow); end
        n_checks++; if (record_count !== 16'(exp_records)) begin n_fail++; $display("FAIL random_record_count: got %0d expected %0d", record_count, exp_records); end
    endtask

    task automatic test_overflow();
        obs_q.delete(); exp_q.delete();
        m_ready = 1'b0;
        stim.delete();
        for (int i = 0; i < 12; i++) stim.push_back(int'($urandom_range(0, 16383)) - 8192);
        model_record(11);
        void'(exp_q.pop_back());
        drive_record(11);
        step(); step();
        n_checks++; if (word_count !== 3'd5) begin n_fail++; $display("FAIL ovf_word_count: got %0d expected 5", word_count); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
        m_ready = 1'b1;
        drain(50);
        m_ready = 1'b0;
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ovf_count: got %0d words expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_midreset();
        m_ready = 1'b1;
        max_sample_cnt = 24'd3;
        for (int i = 0; i < 3; i++) begin
            data_in = 14'(i + 40); write_enable = 1'b1;
            step();
        end
        rst_n = 1'b0;
        #2;
        n_checks++; if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 32'h0) begin n_fail++; $display("FAIL mid_reset_out: got valid=%b last=%b data=%h expected 0 0 0", m_valid, m_last, m_data); end
        n_checks++; if (word_count !== '0 || overflow !== 1'b0 || record_count !== 16'h0) begin n_fail++; $display("FAIL mid_reset_status: got count=%0d ovf=%b rec=%0d expected 0 0 0", word_count, overflow, record_count); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_records = 0;
        data_in = 14'sd77;
        step(); step();
        write_enable = 1'b0;
        step();
        obs_q.delete(); exp_q.delete();
        n_checks++; if (m_valid !== 1'b0 || word_count !== '0) begin n_fail++; $display("FAIL mid_ignore: got valid=%b count=%0d expected 0 0", m_valid, word_count); end
        stim = '{-3, 4, 8191, -8192};
        model_record(3);
        drive_record(3);
        drain(50);
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL mid_count: got %0d words expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL mid_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (record_count !== 16'd1) begin n_fail++; $display("FAIL mid_record_count: got %0d expected 1", record_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_odd_record();
        test_fwft_stall();
        test_back_to_back();
        test_random();
        test_overflow();
        test_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/capture_readout.md
CAPTURE_READOUT -- requirements
Module: capture_readout

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning FIFO depth = 2^ADDR_W 32-bit words.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port data_in  input  14  two's-complement ADC sample from the trigger FSM.
REQ-005 SHALL have port write_enable  input  1  data_in valid this cycle; a contiguous high run is one record.
REQ-006 SHALL have port max_sample_cnt  input  24  samples per record minus 1; held stable during capture and readout.
REQ-007 SHALL have port m_data  output  32  packed word to the PS side.
REQ-008 SHALL have port m_valid  output  1  m_data is valid.
REQ-009 SHALL have port m_ready  input  1  consumer accepts; a transfer occurs on an edge with m_valid=1 and m_ready=1.
REQ-010 SHALL have port m_last  output  1  m_data is the final word of a record.
REQ-011 SHALL have port word_count  output  ADDR_W+1  words currently stored, output register included.
REQ-012 SHALL have port overflow  output  1  sticky flag: a word was dropped.
REQ-013 SHALL have port clear_overflow  input  1  a one-cycle pulse clears overflow.
REQ-014 SHALL have port record_count  output  16  completed records packed on the input side; wraps modulo 2^16.

Function
REQ-015 Packer SHALL have states EMPTY and HAVE_LOW; a sample in EMPTY is held as the low half and moves the packer to HAVE_LOW.
REQ-016 A sample in HAVE_LOW SHALL complete the word {sext16(sample), sext16(low)} and return the packer to EMPTY.
REQ-017 End of record SHALL be write_enable=0 with write_enable=1 on the previous cycle.
REQ-018 At end of record in HAVE_LOW, the packer SHALL emit {16'h0000, sext16(low)} and return to EMPTY.
REQ-019 At end of record, record_count SHALL increment by 1.
REQ-020 A completed word SHALL be written to the FIFO on the edge after its completing sample or end-of-record cycle.
REQ-021 When the FIFO is full at a write, the word SHALL be dropped regardless of a simultaneous read, and overflow SHALL be set.
REQ-022 If a drop and clear_overflow occur on the same cycle, set SHALL win.
REQ-023 Output SHALL be first-word-fall-through: with the FIFO empty, a word written at edge N SHALL make m_valid=1 after edge N+1.
REQ-024 m_data and m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-025 m_valid SHALL deassert after a transfer only if no further word is stored.
REQ-026 Back-to-back transfers, one per cycle, SHALL be sustained while words are stored.
REQ-027 Words per record SHALL be W = floor(max_sample_cnt/2)+1; this covers max_sample_cnt = 0 (W = 1).
REQ-028 An output-side index SHALL count transfers from 0 to W-1 and then wrap to 0.
REQ-029 m_last SHALL equal 1 exactly when the index equals W-1.
REQ-030 word_count SHALL change by +1 per accepted write, -1 per transfer, and 0 when both occur in the same cycle; it SHALL never exceed 2^ADDR_W+1.
REQ-031 FIFO read and write pointers SHALL wrap modulo 2^ADDR_W.
REQ-032 A new record starting while earlier records remain unread SHALL be accepted while space remains.

Reset
REQ-033 While rst_n=0, the block SHALL force m_valid=0, m_last=0, m_data=0, word_count=0, overflow=0, record_count=0, packer=EMPTY, pointers=0, and output index=0.
REQ-034 Reset asserted mid-record SHALL discard the half-packed sample and all stored words.
REQ-035 After rst_n rises, the block SHALL ignore write_enable until it has been observed low for one cycle.

Verification
REQ-036 max_sample_cnt=3, samples 1,2,-1,-2, m_ready=1 -> words 0x00020001, 0xFFFEFFFF; m_last on the second word; record_count=1.
REQ-037 max_sample_cnt=2, samples 5,6,7 -> words 0x00060005, 0x00000007; m_last=1 on 0x00000007.
REQ-038 ADDR_W=2, m_ready=0, 12 samples -> 4 words stored plus 1 in the output register; last word dropped; overflow=1; clear_overflow pulse -> overflow=0.
REQ-039 Write at edge N into an empty FIFO -> m_valid=1 after N+1; m_ready held 0 for 3 cycles -> m_data unchanged.
REQ-040 rst_n pulsed low after 3 samples of a 4-sample record -> all outputs at reset values; next full record packs correctly starting from the low half.
